// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : prog_loader_pkg
//  Brief   : Shared state encoding and frame constants for the program loader.
//  Revision: 1.0  initial release
// ============================================================================
package prog_loader_pkg;

    localparam int LEN_BYTES = 2;

    typedef enum logic [2:0] {
        LEN0 = 3'd0,
        LEN1 = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module  : word_assembler
//  Brief   : Packs four consecutive stream bytes into a little-endian word.
//  Revision: 1.0  initial release
// ============================================================================
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  r_lane;
    // Only the three older bytes are stored; the fourth arrives on the bus.
    logic [23:0] r_shift;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_lane  <= 2'd0;
            r_shift <= 24'd0;
        end else if (byte_valid) begin
            r_lane  <= r_lane + 2'd1;
            r_shift <= {byte_data, r_shift[23:8]};
        end
    end

    assign word_valid = byte_valid && (r_lane == 2'd3);
    assign word_data  = {byte_data, r_shift};

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module  : prog_loader
//  Brief   : Boot loader: byte stream -> LE words -> memory, holds cpu in reset.
//            Define PROG_LOADER_CHECKSUM_EN to require a trailing checksum byte.
//  Revision: 1.0  initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              load_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam int c_len_w = 8 * LEN_BYTES;

    state_t               r_state;
    state_t               w_state_next;
    logic [7:0]           r_len_lo;
    logic [c_len_w-1:0]   r_len;
    logic [c_len_w-1:0]   r_word_cnt;
    logic [c_len_w-1:0]   w_len_full;
    logic                 w_xfer;
    logic                 w_restart;
    logic                 w_byte_valid;
    logic                 w_word_valid;
    logic [31:0]          w_word_data;
    logic                 w_last_word;
    logic                 w_ready_next;
    logic                 w_done_next;
    logic                 w_err_next;

    logic                 r_s_ready;
    logic                 r_mem_we;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [31:0]          r_mem_wdata;
    logic                 r_cpu_rst;
    logic                 r_done;
    logic                 r_err;

    assign w_xfer       = s_valid && r_s_ready;
    assign w_restart    = load_req && ((r_state == DONE) || (r_state == ERR));
    assign w_byte_valid = w_xfer && (r_state == DATA);
    assign w_len_full   = {s_data, r_len_lo};
    assign w_last_word  = (r_word_cnt == (r_len - c_len_w'(1)));

    word_assembler u_word_assembler (
        .clk        (clk),
        .rst        (rst),
        .clr        (w_restart),
        .byte_valid (w_byte_valid),
        .byte_data  (s_data),
        .word_valid (w_word_valid),
        .word_data  (w_word_data)
    );

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t c_after_data = CHK;

    logic [7:0] r_sum;

    always_ff @(posedge clk) begin
        if (rst || w_restart) begin
            r_sum <= 8'd0;
        end else if (w_byte_valid) begin
            r_sum <= r_sum + s_data;
        end
    end
`else
    localparam state_t c_after_data = DONE;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LEN0;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LEN0: if (w_xfer) w_state_next = LEN1;
            LEN1: begin
                if (w_xfer) begin
                    if (w_len_full == '0) begin
                        w_state_next = c_after_data;
                    end else if (int'(w_len_full) > MAX_WORDS) begin
                        w_state_next = ERR;
                    end else begin
                        w_state_next = DATA;
                    end
                end
            end
            DATA: if (w_word_valid && w_last_word) w_state_next = c_after_data;
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK:  if (w_xfer) w_state_next = (s_data == r_sum) ? DONE : ERR;
`endif
            DONE: if (load_req) w_state_next = LEN0;
            ERR:  if (load_req) w_state_next = LEN0;
            default: w_state_next = LEN0;
        endcase
    end

    // done waits one cycle in DONE so it always trails the final write strobe.
    always_comb begin
        w_ready_next = 1'b0;
        case (w_state_next)
            LEN0, LEN1, DATA, CHK: w_ready_next = 1'b1;
            default:               w_ready_next = 1'b0;
        endcase
        w_done_next = (r_state == DONE) && (w_state_next == DONE);
        w_err_next  = (w_state_next == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_lo <= 8'd0;
            r_len    <= '0;
        end else if (w_xfer && (r_state == LEN0)) begin
            r_len_lo <= s_data;
        end else if (w_xfer && (r_state == LEN1)) begin
            r_len    <= w_len_full;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_restart || (w_xfer && (r_state == LEN1))) begin
            r_word_cnt <= '0;
        end else if (w_word_valid) begin
            r_word_cnt <= r_word_cnt + c_len_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_ready   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_cpu_rst   <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_s_ready <= w_ready_next;
            r_mem_we  <= w_word_valid;
            if (w_word_valid) begin
                r_mem_addr  <= r_word_cnt[ADDR_W-1:0];
                r_mem_wdata <= w_word_data;
            end
            r_cpu_rst <= ~w_done_next;
            r_done    <= w_done_next;
            r_err     <= w_err_next;
        end
    end

    assign s_ready   = r_s_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_rst   = r_cpu_rst;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module  : tb_prog_loader
//  Brief   : Self-checking bench for prog_loader with a frame-level reference model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_prog_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 256;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              s_valid  = 1'b0;
    logic [7:0]        s_data   = 8'd0;
    logic              load_req = 1'b0;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .load_req  (load_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: frame position arithmetic ----------------
    localparam int M_LOAD = 0;
    localparam int M_DONE = 1;
    localparam int M_ERR  = 2;

    int          m_stat;
    int          m_prev;
    int          m_idx;
    int          m_len;
    int          m_p;
    logic [7:0]  m_lo;
    logic [7:0]  m_sum;
    logic [31:0] m_word;
    logic        e_ready;
    logic        e_we;
    logic        e_cpu_rst;
    logic        e_done;
    logic        e_err;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata;

    task payload_end();
`ifndef PROG_LOADER_CHECKSUM_EN
        m_stat = M_DONE;
`endif
    endtask

    task model_byte(input logic [7:0] b);
        if (m_idx == 0) begin
            m_lo = b;
        end else if (m_idx == 1) begin
            m_len = int'({b, m_lo});
            if (m_len > MAX_WORDS) m_stat = M_ERR;
            else if (m_len == 0)   payload_end();
        end else if (m_idx < 2 + 4 * m_len) begin
            m_p = m_idx - 2;
            m_word[8 * (m_p % 4) +: 8] = b;
            m_sum = m_sum + b;
            if (m_p % 4 == 3) begin
                e_we    = 1'b1;
                e_addr  = 8'(m_p / 4);
                e_wdata = m_word;
            end
            if (m_p == 4 * m_len - 1) payload_end();
        end else begin
            m_stat = (b == m_sum) ? M_DONE : M_ERR;
        end
        m_idx++;
    endtask

    initial begin
        m_stat = M_LOAD; m_idx = 0; m_len = 0; m_sum = 8'd0; m_lo = 8'd0; m_word = 32'd0;
        e_ready = 1'b0; e_we = 1'b0; e_cpu_rst = 1'b1; e_done = 1'b0; e_err = 1'b0;
        e_addr = 8'd0; e_wdata = 32'd0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_stat = M_LOAD; m_idx = 0; m_sum = 8'd0;
                e_ready = 1'b0; e_we = 1'b0; e_cpu_rst = 1'b1; e_done = 1'b0; e_err = 1'b0;
                e_addr = 8'd0; e_wdata = 32'd0;
            end else begin
                m_prev = m_stat;
                e_we   = 1'b0;
                if (m_stat == M_LOAD && s_valid && e_ready) begin
                    model_byte(s_data);
                end else if (m_stat != M_LOAD && load_req) begin
                    m_stat = M_LOAD; m_idx = 0; m_sum = 8'd0;
                end
                e_ready   = (m_stat == M_LOAD);
                e_err     = (m_stat == M_ERR);
                e_done    = (m_prev == M_DONE) && (m_stat == M_DONE);
                e_cpu_rst = !e_done;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk1("s_ready", s_ready, e_ready);
            chk1("mem_we", mem_we, e_we);
            chk1("cpu_rst", cpu_rst, e_cpu_rst);
            chk1("done", done, e_done);
            chk1("err", err, e_err);
            if (e_we) begin
                chk32("mem_addr", 32'(mem_addr), 32'(e_addr));
                chk32("mem_wdata", mem_wdata, e_wdata);
            end
        end
    end

    // Shadow memory built from observed writes, pinned by literal checks.
    logic [31:0] shadow [256];
    int          n_writes;
    initial begin
        n_writes = 0;
        foreach (shadow[i]) shadow[i] = 32'd0;
        forever begin
            @(posedge clk);
            if (mem_we === 1'b1) begin
                shadow[mem_addr] = mem_wdata;
                n_writes++;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] g_words [256];
    bit          g_noise = 1'b0;

    task automatic send_byte(input logic [7:0] b, input int gap);
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid  = 1'b1;
        s_data   = b;
        load_req = g_noise && ($urandom_range(0, 7) == 0);
        for (int t = 0; t < 50 && !s_ready; t++) @(negedge clk);
        chk1("ready_timeout", s_ready, 1'b1);
        if (s_ready) @(negedge clk);
        s_valid  = 1'b0;
        load_req = 1'b0;
    endtask

    task automatic send_frame(input int n, input int gap_max, input int gap_idx,
                              input bit bad_chk, input int abort_at);
        logic [7:0]  q[$];
        logic [7:0]  sum;
        logic [31:0] w;
        int          gap;
        sum = 8'd0;
        q.push_back(8'(n));
        q.push_back(8'(n >> 8));
        if (n <= MAX_WORDS) begin
            for (int i = 0; i < n; i++) begin
                w = g_words[i];
                for (int k = 0; k < 4; k++) begin
                    q.push_back(w[8 * k +: 8]);
                    sum = sum + w[8 * k +: 8];
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            q.push_back(bad_chk ? ((sum == 8'd0) ? 8'hFF : 8'h00) : sum);
`endif
        end
        foreach (q[i]) begin
            if (i == abort_at) begin
                s_valid = 1'b0;
                rst     = 1'b1;
                @(negedge clk);
                rst     = 1'b0;
                return;
            end
            if (i == gap_idx)                                      gap = 3;
            else if (gap_max > 0 && $urandom_range(0, 3) == 0)     gap = $urandom_range(1, gap_max);
            else                                                   gap = 0;
            send_byte(q[i], gap);
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_end();
        for (int t = 0; t < 20 && !(done || err); t++) @(negedge clk);
        chk1("end_timeout", done || err, 1'b1);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    int n0;

    initial begin
        repeat (2) @(negedge clk);
        chk1("rst_cpu_rst", cpu_rst, 1'b1);
        chk1("rst_s_ready", s_ready, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk32("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        // Spec frame N=2, back to back.
        g_words[0] = 32'h0100_0113;
        g_words[1] = 32'h0AA0_0193;
        send_frame(2, 0, -1, 1'b0, -1);
        wait_end();
        @(negedge clk);
        chk1("n2_done", done, 1'b1);
        chk1("n2_cpu_rst", cpu_rst, 1'b0);
        chk32("n2_word0", shadow[0], 32'h0100_0113);
        chk32("n2_word1", shadow[1], 32'h0AA0_0193);
        chk32("n2_writes", 32'(n_writes), 32'd2);

        // Reload overwrites word 0 only.
        pulse_load();
        chk1("reload_cpu_rst", cpu_rst, 1'b1);
        chk1("reload_done", done, 1'b0);
        g_words[0] = 32'hDEAD_BEEF;
        send_frame(1, 0, -1, 1'b0, -1);
        wait_end();
        chk1("reload_done2", done, 1'b1);
        chk32("reload_word0", shadow[0], 32'hDEAD_BEEF);
        chk32("reload_word1", shadow[1], 32'h0AA0_0193);

        // Same N=2 frame with valid low for 3 cycles mid-word.
        pulse_load();
        g_words[0] = 32'h0100_0113;
        n0 = n_writes;
        send_frame(2, 0, 4, 1'b0, -1);
        wait_end();
        chk1("gap_done", done, 1'b1);
        chk32("gap_word0", shadow[0], 32'h0100_0113);
        chk32("gap_word1", shadow[1], 32'h0AA0_0193);
        chk32("gap_writes", 32'(n_writes - n0), 32'd2);

        // Oversize length 0x0101.
        pulse_load();
        n0 = n_writes;
        send_frame(257, 0, -1, 1'b0, -1);
        wait_end();
        chk1("over_err", err, 1'b1);
        chk1("over_cpu_rst", cpu_rst, 1'b1);
        chk1("over_s_ready", s_ready, 1'b0);
        chk32("over_writes", 32'(n_writes - n0), 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
        pulse_load();
        g_words[0] = 32'h0000_006F;
        send_frame(1, 0, -1, 1'b0, -1);
        wait_end();
        chk1("chk_ok_done", done, 1'b1);
        chk32("chk_ok_word0", shadow[0], 32'h0000_006F);
        pulse_load();
        send_frame(1, 0, -1, 1'b1, -1);
        wait_end();
        chk1("chk_bad_err", err, 1'b1);
        chk1("chk_bad_cpu_rst", cpu_rst, 1'b1);
`endif

        // Empty program.
        pulse_load();
        n0 = n_writes;
        send_frame(0, 0, -1, 1'b0, -1);
        wait_end();
        @(negedge clk);
        chk1("n0_done", done, 1'b1);
        chk32("n0_writes", 32'(n_writes - n0), 32'd0);

        // Largest program.
        pulse_load();
        foreach (g_words[i]) g_words[i] = $urandom;
        n0 = n_writes;
        send_frame(MAX_WORDS, 0, -1, 1'b0, -1);
        wait_end();
        @(negedge clk);
        chk1("max_done", done, 1'b1);
        chk32("max_writes", 32'(n_writes - n0), 32'(MAX_WORDS));
        chk32("max_last", shadow[MAX_WORDS - 1], g_words[MAX_WORDS - 1]);

        // Randomized frames with gaps, stray load_req, bad checksums and resets.
        pulse_load();
        g_noise = 1'b1;
        for (int f = 0; f < 30; f++) begin
            int n;
            int abort_at;
            bit bad;
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(MAX_WORDS + 1, 65535)
                                            : $urandom_range(0, 5);
            for (int i = 0; i < 8; i++) g_words[i] = $urandom;
            bad      = ($urandom_range(0, 3) == 0);
            abort_at = (n <= MAX_WORDS && $urandom_range(0, 5) == 0) ? $urandom_range(1, 4 * n + 1) : -1;
            send_frame(n, 2, -1, bad, abort_at);
            if (abort_at < 0) begin
                wait_end();
                repeat ($urandom_range(0, 2)) @(negedge clk);
                pulse_load();
            end
        end
        g_noise = 1'b0;

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
